// File: rtl/mpe_pkg.sv
// Shared types and default widths for the matrix_pe job sequencer.
package mpe_pkg;

  localparam int unsigned MPE_ADDR_W = 10;
  localparam int unsigned MPE_LEN_W  = 8;
  localparam int unsigned MPE_ROW_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UOP,
    ST_STREAM,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } mpe_state_e;

  // Field widths follow the package defaults; the top casts into/out of them.
  typedef struct packed {
    logic [MPE_ADDR_W-1:0] n_base;
    logic [MPE_ADDR_W-1:0] w_base;
    logic [MPE_ADDR_W-1:0] o_base;
    logic [MPE_LEN_W-1:0]  len;
    logic [MPE_ROW_W-1:0]  rows;
  } mpe_desc_t;

endpackage

// File: rtl/mpe_addr_gen.sv
// Beat/row counters and NRAM/WRAM read-address generation for one job.
module mpe_addr_gen
  import mpe_pkg::*;
#(
  parameter int unsigned ADDR_W = MPE_ADDR_W,
  parameter int unsigned LEN_W  = MPE_LEN_W,
  parameter int unsigned ROW_W  = MPE_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              stream,
  input  logic              row_adv,
  input  logic [ADDR_W-1:0] n_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  output logic [ADDR_W-1:0] wram_addr,
  output logic              last_beat,
  output logic [ROW_W-1:0]  row
);

  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;

  always_comb begin
    last_beat = stream && (beat_q == (len - LEN_W'(1)));
    rd_en     = stream;
    nram_addr = '0;
    wram_addr = '0;
    if (stream) begin
      nram_addr = n_base + ADDR_W'(beat_q);
      wram_addr = w_base + row_off_q + ADDR_W'(beat_q);
    end
    row = row_q;
  end

  // row_off accumulates len per finished row, standing in for row*len.
  always_comb begin
    beat_d    = beat_q;
    row_d     = row_q;
    row_off_d = row_off_q;
    if (clear) begin
      beat_d    = '0;
      row_d     = '0;
      row_off_d = '0;
    end else begin
      if (stream) begin
        if (last_beat) begin
          beat_d    = '0;
          row_off_d = row_off_q + ADDR_W'(len);
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      if (row_adv) begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      row_q     <= '0;
      row_off_q <= '0;
    end else begin
      beat_q    <= beat_d;
      row_q     <= row_d;
      row_off_q <= row_off_d;
    end
  end

endmodule

// File: rtl/mpe_sched.sv
// Job-level sequencer: issues per-row uops to matrix_pe, drives SRAM reads
// and writes returned PE results to the output buffer.
module mpe_sched
  import mpe_pkg::*;
#(
  parameter int unsigned ADDR_W = MPE_ADDR_W,
  parameter int unsigned LEN_W  = MPE_LEN_W,
  parameter int unsigned ROW_W  = MPE_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_n_base,
  input  logic [ADDR_W-1:0] cmd_w_base,
  input  logic [ADDR_W-1:0] cmd_o_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ROW_W-1:0]  cmd_rows,
  output logic [LEN_W-1:0]  uop,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_rd_addr,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_rd_addr,
  output logic              nram_data_valid,
  output logic              wram_data_valid,
  input  logic [31:0]       mpe_result,
  input  logic              mpe_vld,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mpe_state_e        state_q, state_d;
  mpe_desc_t         desc_q, desc_d;
  logic [ROW_W-1:0]  res_cnt_q, res_cnt_d;
  logic              err_q, err_d;
  logic              out_we_q, out_we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_wdata_q, out_wdata_d;
  logic              nram_dv_q, nram_dv_d;
  logic              wram_dv_q, wram_dv_d;

  logic              accept, row_adv, stream, last_beat, rd_en, wr_fire;
  logic [ROW_W-1:0]  row;
  logic [ROW_W:0]    row_nxt;
  logic [ADDR_W-1:0] n_base, w_base, o_base;
  logic [LEN_W-1:0]  len;
  logic [ROW_W-1:0]  rows;

  assign n_base = ADDR_W'(desc_q.n_base);
  assign w_base = ADDR_W'(desc_q.w_base);
  assign o_base = ADDR_W'(desc_q.o_base);
  assign len    = LEN_W'(desc_q.len);
  assign rows   = ROW_W'(desc_q.rows);

  mpe_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W),
    .ROW_W (ROW_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .stream   (stream),
    .row_adv  (row_adv),
    .n_base   (n_base),
    .w_base   (w_base),
    .len      (len),
    .rd_en    (rd_en),
    .nram_addr(nram_rd_addr),
    .wram_addr(wram_rd_addr),
    .last_beat(last_beat),
    .row      (row)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    row_adv   = 1'b0;
    stream    = 1'b0;
    cmd_ready = 1'b0;
    uop_valid = 1'b0;
    done      = 1'b0;
    row_nxt   = {1'b0, row} + {{ROW_W{1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_len == '0 || cmd_rows == '0) ? ST_DONE : ST_UOP;
        end
      end
      ST_UOP: begin
        uop_valid = 1'b1;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        stream = 1'b1;
        if (last_beat) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (uop_ready) begin
          row_adv = 1'b1;
          state_d = (row_nxt < {1'b0, rows}) ? ST_UOP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_cnt_q == rows) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy = (state_q != ST_IDLE);
    uop  = uop_valid ? len : '0;
  end

  // Results are written whenever busy, so they may overlap later rows.
  always_comb begin
    wr_fire = mpe_vld && busy;
    desc_d  = desc_q;
    if (accept) begin
      desc_d.n_base = MPE_ADDR_W'(cmd_n_base);
      desc_d.w_base = MPE_ADDR_W'(cmd_w_base);
      desc_d.o_base = MPE_ADDR_W'(cmd_o_base);
      desc_d.len    = MPE_LEN_W'(cmd_len);
      desc_d.rows   = MPE_ROW_W'(cmd_rows);
    end
    res_cnt_d = res_cnt_q;
    if (accept) begin
      res_cnt_d = '0;
    end else if (wr_fire) begin
      res_cnt_d = res_cnt_q + ROW_W'(1);
    end
    err_d       = err_q | (mpe_vld & ~busy) | (uop_ready & (state_q != ST_WAIT));
    out_we_d    = wr_fire;
    out_addr_d  = wr_fire ? (o_base + ADDR_W'(res_cnt_q)) : '0;
    out_wdata_d = wr_fire ? mpe_result : '0;
    nram_dv_d   = rd_en;
    wram_dv_d   = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      res_cnt_q   <= '0;
      err_q       <= 1'b0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      nram_dv_q   <= 1'b0;
      wram_dv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      res_cnt_q   <= res_cnt_d;
      err_q       <= err_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_wdata_q <= out_wdata_d;
      nram_dv_q   <= nram_dv_d;
      wram_dv_q   <= wram_dv_d;
    end
  end

  assign nram_rd_en      = rd_en;
  assign wram_rd_en      = rd_en;
  assign nram_data_valid = nram_dv_q;
  assign wram_data_valid = wram_dv_q;
  assign out_we          = out_we_q;
  assign out_addr        = out_addr_q;
  assign out_wdata       = out_wdata_q;
  assign err             = err_q;

endmodule
